// File: rtl/weight_fifo_arr_loader.sv
// Weight-load responder: pops weight rows from the show-ahead FIFO,
// zero-pads the unused rows, shifts them into the array and commits them.
module weight_fifo_arr_loader #(
  parameter int width_height = 16,
  parameter int CNT_W        = $clog2(width_height) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             weight_fifo_arr_en,
  input  logic [CNT_W-1:0] num_row_weight_mat,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  output logic             weight_shift,
  output logic             zero_fill,
  output logic             weight_load,
  output logic             busy,
  output logic             weight_fifo_arr_done
);

  localparam logic [CNT_W-1:0] WH = CNT_W'(width_height);

  typedef enum logic [2:0] {
    IDLE,
    ZERO,
    REAL,
    LOAD,
    DONE,
    REARM
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] nrows, nrows_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      nrows <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      nrows <= nrows_nx;
    end
  end

  // cnt tracks total shifts, so zero and real phases share one counter
  always_comb begin
    state_nx             = state;
    cnt_nx               = cnt;
    nrows_nx             = nrows;
    fifo_pop             = 1'b0;
    weight_shift         = 1'b0;
    zero_fill            = 1'b0;
    weight_load          = 1'b0;
    busy                 = 1'b1;
    weight_fifo_arr_done = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (weight_fifo_arr_en) begin
          nrows_nx = (num_row_weight_mat > WH) ? WH : num_row_weight_mat;
          cnt_nx   = '0;
          state_nx = (nrows_nx == WH) ? REAL : ZERO;
        end
      end
      ZERO: begin
        weight_shift = 1'b1;
        zero_fill    = 1'b1;
        cnt_nx       = cnt + 1'b1;
        if (cnt == WH - nrows - 1'b1)
          state_nx = (nrows == '0) ? LOAD : REAL;
      end
      REAL: begin
        fifo_pop     = !fifo_empty;
        weight_shift = !fifo_empty;
        if (!fifo_empty) begin
          cnt_nx = cnt + 1'b1;
          if (cnt_nx == WH)
            state_nx = LOAD;
        end
      end
      LOAD: begin
        weight_load = 1'b1;
        state_nx    = DONE;
      end
      DONE: begin
        weight_fifo_arr_done = 1'b1;
        state_nx             = REARM;
      end
      REARM: begin
        if (!weight_fifo_arr_en)
          state_nx = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_weight_fifo_arr_loader.sv
// Bench for weight_fifo_arr_loader: table vectors, corner sequences
// and randomized loads against a row-phase reference model.
module tb_weight_fifo_arr_loader;

  localparam int W     = 16;
  localparam int CNT_W = $clog2(W) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [CNT_W-1:0] num;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             weight_shift;
  logic             zero_fill;
  logic             weight_load;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  weight_fifo_arr_loader #(.width_height(W), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .weight_fifo_arr_en   (en),
    .num_row_weight_mat   (num),
    .fifo_empty           (fifo_empty),
    .fifo_pop             (fifo_pop),
    .weight_shift         (weight_shift),
    .zero_fill            (zero_fill),
    .weight_load          (weight_load),
    .busy                 (busy),
    .weight_fifo_arr_done (done)
  );

  typedef struct {
    int n;
    int stall_at;
    int stall_len;
    bit drop_mid;
    int hold;
    int exp_done;
    int exp_pops;
    int exp_zf;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [5:0] outs();
    return {fifo_pop, weight_shift, zero_fill, weight_load, busy, done};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: W-nr zero rows, then nr FIFO rows (stalling while empty),
  // then one load cycle, then one done cycle.
  task automatic run_op(input int n, input int stall_at, input int stall_len,
                        input bit rnd, input bit drop_mid, input int hold,
                        output int done_cyc, output int pops,
                        output int shifts, output int zf, output int stalls);
    int nr, zl, rl, sl;
    bit ld, fin, emp;
    logic [5:0] expv;
    nr = (n > W) ? W : n;
    zl = W - nr;
    rl = nr;
    sl = 0;
    ld = 0;
    fin = 0;
    pops = 0;
    shifts = 0;
    zf = 0;
    stalls = 0;
    done_cyc = -1;
    en = 1'b1;
    num = CNT_W'(n);
    @(posedge clk); #1;
    num = CNT_W'($urandom);
    for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
      if (rnd)
        emp = ($urandom_range(0, 3) == 0);
      else
        emp = (stall_at >= 0 && pops == stall_at && sl < stall_len);
      if (emp && !rnd) sl++;
      fifo_empty = emp;
      if (drop_mid && cyc == 3) en = 1'b0;
      #1;
      if (zl > 0) begin
        expv = 6'b011010;
        zl--;
      end else if (rl > 0) begin
        expv = {~emp, ~emp, 4'b0010};
        if (!emp) rl--;
        else stalls++;
      end else if (!ld) begin
        expv = 6'b000110;
        ld = 1;
      end else begin
        expv = 6'b000011;
        fin = 1;
        done_cyc = cyc;
      end
      check("cycle_outputs", int'(outs()), int'(expv));
      pops   += int'(fifo_pop);
      shifts += int'(weight_shift);
      zf     += int'(zero_fill);
      @(posedge clk); #1;
    end
    if (!fin) check("done_timeout", 0, 1);
    fifo_empty = 1'b0;
    check("rearm_busy", int'(outs()), 6'b000010);
    repeat (hold) begin
      @(posedge clk); #1;
      check("rearm_hold", int'(outs()), 6'b000010);
    end
    en = 1'b0;
    @(posedge clk); #1;
    check("back_to_idle", int'(outs()), 0);
  endtask

  initial begin
    int dc, p, s, z, st, cnt, nn;
    tbl[0] = '{16, -1, 0, 1'b0, 0, 18, 16, 0};
    tbl[1] = '{5,  -1, 0, 1'b0, 0, 18, 5, 11};
    tbl[2] = '{0,  -1, 0, 1'b0, 0, 18, 0, 16};
    tbl[3] = '{20, -1, 0, 1'b0, 0, 18, 16, 0};
    tbl[4] = '{16,  4, 3, 1'b0, 0, 21, 16, 0};
    tbl[5] = '{16, -1, 0, 1'b0, 4, 18, 16, 0};
    tbl[6] = '{9,  -1, 0, 1'b1, 0, 18, 9, 7};

    reset = 1'b1;
    en = 1'b0;
    num = '0;
    fifo_empty = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", int'(outs()), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", int'(outs()), 0);

    foreach (tbl[i]) begin
      run_op(tbl[i].n, tbl[i].stall_at, tbl[i].stall_len, 1'b0,
             tbl[i].drop_mid, tbl[i].hold, dc, p, s, z, st);
      check($sformatf("vec%0d_done_cycle", i), dc, tbl[i].exp_done);
      check($sformatf("vec%0d_pops", i), p, tbl[i].exp_pops);
      check($sformatf("vec%0d_shifts", i), s, W);
      check($sformatf("vec%0d_zero_fill", i), z, tbl[i].exp_zf);
    end

    // reset mid-REAL after 7 pops
    en = 1'b1;
    num = CNT_W'(16);
    @(posedge clk); #1;
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 7; c++) begin
      fifo_empty = 1'b0;
      #1;
      cnt += int'(fifo_pop);
      @(posedge clk); #1;
    end
    check("pops_before_reset", cnt, 7);
    check("mid_real_pop", int'(fifo_pop), 1);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", int'(outs()), 0);
    repeat (2) begin
      @(posedge clk); #1;
      check("no_done_in_reset", int'(outs()), 0);
    end
    en = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_abort", int'(outs()), 0);
    run_op(16, -1, 0, 1'b0, 1'b0, 0, dc, p, s, z, st);
    check("post_reset_done_cycle", dc, 18);
    check("post_reset_pops", p, 16);

    for (int r = 0; r < 8; r++) begin
      nn = $urandom_range(0, 31);
      run_op(nn, -1, 0, 1'b1, 1'b0, $urandom_range(0, 2), dc, p, s, z, st);
      check("rnd_done_cycle", dc, W + 2 + st);
      check("rnd_pops", p, (nn > W) ? W : nn);
      check("rnd_shifts", s, W);
      check("rnd_zero_fill", z, W - ((nn > W) ? W : nn));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_fifo_arr_loader.md
Name: weight_fifo_arr_loader

Overview:
- Responder side of the master multiply controller's weight-load handshake.
- Consumes `weight_fifo_arr_en`, pops weight rows from the show-ahead weight FIFO and shifts them into the systolic array's weight chain.
- Pads unused rows with zeros, commits the chain into the PEs, then returns a one-cycle `weight_fifo_arr_done`.
- Sits between the master multiply controller, the weight FIFO and the systolic array.

Parameters:
- width_height, 16, systolic array height and width; number of rows shifted per load.
- CNT_W, $clog2(width_height)+1, width of the row count and row counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- weight_fifo_arr_en  input  1  start request from master; level, held until done.
- num_row_weight_mat  input  CNT_W  number of real weight rows; sampled at start.
- fifo_empty  input  1  weight FIFO has no row available.
- fifo_pop  output  1  pop one row; FIFO output data is valid in the same cycle.
- weight_shift  output  1  array weight chain shifts by one row this cycle.
- zero_fill  output  1  array injects an all-zero row instead of FIFO data; only with weight_shift.
- weight_load  output  1  array copies the chain into the PE weight registers.
- busy  output  1  high in every state except IDLE.
- weight_fifo_arr_done  output  1  one-cycle completion pulse to master.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, row counter=0, latched count=0.
  - All outputs 0.
  - Reset mid-operation aborts with no done pulse; rows already popped are lost, and the master must reset the FIFO too.
- Outputs are Moore/combinational decodes of the state, the counter and fifo_empty. No output is registered beyond the state.
- States:
  - IDLE: when en=1 at the edge, latch nrows = min(num_row_weight_mat, width_height), clear the counter, go to ZERO. If nrows==width_height, go directly to REAL.
  - ZERO: shifts width_height-nrows zero rows, one per cycle.
    - weight_shift=1, zero_fill=1, fifo_pop=0.
    - Counter increments each cycle; on the last zero row go to REAL. If nrows==0, go to LOAD instead.
    - Zero rows go first so they end at the deepest rows, width_height-1 downward.
  - REAL: shifts nrows FIFO rows.
    - Per cycle: fifo_pop = weight_shift = !fifo_empty, zero_fill=0.
    - Empty FIFO stalls: no shift, no pop, counter holds, no timeout.
    - Counter increments only on a pop. Go to LOAD when the counter reaches width_height after a pop.
    - The FIFO holds rows in reverse order (matrix row nrows-1 first), so matrix row 0 lands in array row 0.
  - LOAD: weight_load=1 for exactly 1 cycle, then go to DONE.
  - DONE: weight_fifo_arr_done=1 for exactly 1 cycle, then go to REARM.
  - REARM: wait for en=0, then go to IDLE. A new operation needs en to fall and rise again; this tolerates the master's en still being high in the done cycle.
- en is ignored in ZERO, REAL, LOAD and DONE; dropping it mid-operation does not abort.
- num_row_weight_mat changes after start are ignored.
- Counter: CNT_W bits, counts 0..width_height, never wraps.
- Latency with no stalls:
  - en sampled at edge N; first shift in cycle N+1.
  - Last shift in cycle N+width_height; weight_load in N+width_height+1; done in N+width_height+2.
  - Each empty-FIFO stall cycle in REAL adds 1.
- Total shifts per operation is exactly width_height; total pops is exactly nrows.

Test Plan:
- width_height=16, nrows=16, FIFO never empty, en at edge 0 -> 16 cycles of fifo_pop=weight_shift=1 with zero_fill=0 (cycles 1-16), weight_load in cycle 17, done in cycle 18, busy low after en falls.
- nrows=5 -> 11 cycles of zero_fill=weight_shift=1 with no pop, then 5 pops; 16 shifts and 5 pops total; done in cycle 18.
- nrows=0 and nrows=20 -> 16 zero shifts and 0 pops; 20 clamps to 16 pops; both complete with exactly one done pulse.
- nrows=16, fifo_empty high for 3 cycles after the 4th pop -> no shift or pop during the stall; done in cycle 21; 16 pops total.
- en held high 4 cycles past done -> no restart, busy=1 in REARM; en low then high -> a second full operation with one done pulse.
- reset asserted mid-REAL after 7 pops -> outputs 0 asynchronously, no done; after release, en starts a fresh 16-row load.
